// File: rtl/wb_tg_pkg.sv
// Shared constants, FSM state enum and LFSR step for the Wishbone SDRAM traffic generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_tg_pkg;

  // Pattern modes selected by cfg_pat_mode
  localparam logic [1:0] PAT_INCR  = 2'd0;  // seed + beat index
  localparam logic [1:0] PAT_ADDR  = 2'd1;  // byte address
  localparam logic [1:0] PAT_LFSR  = 2'd2;  // Galois LFSR
  localparam logic [1:0] PAT_NADDR = 2'd3;  // inverted byte address

  // Wishbone registered-feedback cycle type codes
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_INIT,
    ST_WR,
    ST_GAP,
    ST_RD,
    ST_FIN
  } tg_state_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/wb_tg_pattern_gen.sv
// Pattern/address generator shared by the write and read phases of the traffic generator.
// Latency: outputs reflect the current beat combinationally; load/advance take effect next edge.
// Backpressure: none; the caller advances only on an acknowledged beat.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_load              restart sequence at i_base (aligned) / i_seed
//   i_adv               step to the next beat (address + DW/8, counter + 1, LFSR step)
//   i_mode              pattern selector (wb_tg_pkg PAT_*)
//   o_addr, o_dat       current beat byte address and data
module wb_tg_pattern_gen #(
  parameter int DW = 32,
  parameter int AW = 26
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [31:0]   i_seed,
  input  logic [AW-1:0] i_base,
  input  logic          i_adv,
  input  logic [1:0]    i_mode,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_dat
);
  import wb_tg_pkg::*;

  localparam logic [AW-1:0] BEAT_BYTES = AW'(DW / 8);

  logic [31:0]   r_cnt;
  logic [31:0]   r_lfsr;
  logic [AW-1:0] r_addr;
  logic [31:0]   w_a32;
  logic [31:0]   w_v32;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_lfsr <= '0;
      r_addr <= '0;
    end else if (i_load) begin
      r_cnt  <= i_seed;
      // An all-zero LFSR would lock up
      r_lfsr <= (i_seed == 32'd0) ? 32'd1 : i_seed;
      r_addr <= i_base & ~(BEAT_BYTES - AW'(1));
    end else if (i_adv) begin
      r_cnt  <= r_cnt + 32'd1;
      r_lfsr <= lfsr_step(r_lfsr);
      r_addr <= r_addr + BEAT_BYTES;  // wraps modulo 2^AW
    end
  end

  always_comb begin
    w_a32 = 32'(r_addr);
    case (i_mode)
      PAT_INCR: w_v32 = r_cnt;
      PAT_ADDR: w_v32 = w_a32;
      PAT_LFSR: w_v32 = r_lfsr;
      default:  w_v32 = ~w_a32;
    endcase
  end

  // 32-bit pattern replicated (or truncated) across the data bus
  for (genvar g = 0; g < DW; g++) begin : g_rep
    assign o_dat[g] = w_v32[g % 32];
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/wb_sdram_traffic_gen.sv
// Wishbone master that writes a pattern region in bursts, reads it back and compares.
// Latency: first stb two cycles after start (init done); 1 idle cycle between bursts and phases.
// Backpressure: holds addr/dat/stb until wb_ack_i; aborts after ACK_TIMEOUT cycles without ack.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   sdr_init_done           gates all bus traffic
//   start, cfg_*            run request and configuration (latched on start in IDLE)
//   wb_*_o / wb_ack_i/dat_i Wishbone master interface with burst cycle types
//   busy, done, pass        run status; done is a one-cycle pulse, pass valid with done
//   err_count, first_err_addr, timeout  read-back result of the last run
module wb_sdram_traffic_gen #(
  parameter int DW          = 32,
  parameter int AW          = 26,
  parameter int LEN_W       = 16,
  parameter int BURST_W     = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               sdr_init_done,
  input  logic               start,
  input  logic [AW-1:0]      cfg_base_addr,
  input  logic [LEN_W-1:0]   cfg_num_words,
  input  logic [BURST_W-1:0] cfg_burst_len,
  input  logic [1:0]         cfg_pat_mode,
  input  logic [31:0]        cfg_seed,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [AW-1:0]      wb_addr_o,
  output logic [DW-1:0]      wb_dat_o,
  output logic [DW/8-1:0]    wb_sel_o,
  output logic [2:0]         wb_cti_o,
  input  logic               wb_ack_i,
  input  logic [DW-1:0]      wb_dat_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic [AW-1:0]      first_err_addr,
  output logic               timeout
);
  import wb_tg_pkg::*;

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  tg_state_e          r_state;
  tg_state_e          w_next;

  logic [AW-1:0]      r_cfg_base;
  logic [LEN_W-1:0]   r_cfg_num;
  logic [BURST_W-1:0] r_cfg_burst;
  logic [1:0]         r_cfg_mode;
  logic [31:0]        r_cfg_seed;

  logic [LEN_W-1:0]   r_remain;     // words left in the current phase
  logic [BURST_W-1:0] r_beat_left;  // beats left in the current burst, including this one
  logic [BURST_W-1:0] r_burst_n;    // size of the current burst
  logic               r_act;        // burst on the bus; low for the inter-burst idle cycle
  logic [TO_W-1:0]    r_to_cnt;
  logic [15:0]        r_err;
  logic [AW-1:0]      r_first;
  logic               r_timeout;
  logic               r_pass;

  logic               w_stb;
  logic               w_beat_done;
  logic               w_last_word;
  logic               w_to_hit;
  logic               w_mismatch;
  logic               w_pass_now;
  logic [BURST_W-1:0] w_burst_eff;
  logic [LEN_W-1:0]   w_burst_src;
  logic [BURST_W-1:0] w_burst_next;
  logic               w_pat_load;
  logic               w_pat_adv;
  logic [31:0]        w_load_seed;
  logic [AW-1:0]      w_load_base;
  logic [AW-1:0]      w_pat_addr;
  logic [DW-1:0]      w_pat_dat;

  assign w_stb       = r_act && (r_state == ST_WR || r_state == ST_RD);
  assign w_beat_done = w_stb && wb_ack_i;
  assign w_last_word = (r_remain == LEN_W'(1));
  assign w_to_hit    = w_stb && !wb_ack_i && (r_to_cnt == TO_W'(ACK_TIMEOUT - 1));
  assign w_mismatch  = (r_state == ST_RD) && w_beat_done && (wb_dat_i != w_pat_dat);
  assign w_pass_now  = (r_err == 16'd0) && !r_timeout;

  // Next burst is min(burst_len, remaining words); the read phase starts from the full count
  assign w_burst_eff  = (r_cfg_burst == '0) ? BURST_W'(1) : r_cfg_burst;
  assign w_burst_src  = (r_state == ST_GAP) ? r_cfg_num : r_remain;
  assign w_burst_next = (w_burst_src < LEN_W'(w_burst_eff)) ? BURST_W'(w_burst_src) : w_burst_eff;

  // Generator is reloaded on start and again in GAP so reads regenerate the written sequence
  assign w_pat_load  = (r_state == ST_IDLE && start) || (r_state == ST_GAP);
  assign w_pat_adv   = w_beat_done;
  assign w_load_seed = (r_state == ST_IDLE) ? cfg_seed : r_cfg_seed;
  assign w_load_base = (r_state == ST_IDLE) ? cfg_base_addr : r_cfg_base;

  wb_tg_pattern_gen #(
    .DW (DW),
    .AW (AW)
  ) u_pat (
    .i_clk  (wb_clk_i),
    .i_rst  (wb_rst_i),
    .i_load (w_pat_load),
    .i_seed (w_load_seed),
    .i_base (w_load_base),
    .i_adv  (w_pat_adv),
    .i_mode (r_cfg_mode),
    .o_addr (w_pat_addr),
    .o_dat  (w_pat_dat)
  );

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_next = (cfg_num_words == '0) ? ST_FIN : ST_WAIT_INIT;
      ST_WAIT_INIT: if (sdr_init_done) w_next = ST_WR;
      ST_WR: begin
        if (w_beat_done && w_last_word) w_next = ST_GAP;
        else if (w_to_hit)              w_next = ST_FIN;
      end
      ST_GAP:       w_next = ST_RD;
      ST_RD:        if ((w_beat_done && w_last_word) || w_to_hit) w_next = ST_FIN;
      ST_FIN:       w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // FSM outputs; bus fields are zero whenever no cycle is on the bus
  always_comb begin
    wb_cyc_o       = w_stb;
    wb_stb_o       = w_stb;
    wb_we_o        = w_stb && (r_state == ST_WR);
    wb_addr_o      = w_stb ? w_pat_addr : '0;
    wb_dat_o       = (w_stb && r_state == ST_WR) ? w_pat_dat : '0;
    wb_sel_o       = {(DW/8){w_stb}};
    wb_cti_o       = CTI_CLASSIC;
    if (w_stb && r_burst_n != BURST_W'(1))
      wb_cti_o = (r_beat_left == BURST_W'(1)) ? CTI_EOB : CTI_INCR;
    busy           = (r_state == ST_WAIT_INIT) || (r_state == ST_WR) ||
                     (r_state == ST_GAP) || (r_state == ST_RD);
    done           = (r_state == ST_FIN);
    pass           = (r_state == ST_FIN) ? w_pass_now : r_pass;
    err_count      = r_err;
    first_err_addr = r_first;
    timeout        = r_timeout;
  end

  // Datapath: burst sequencing, timeout and compare
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cfg_base  <= '0;
      r_cfg_num   <= '0;
      r_cfg_burst <= '0;
      r_cfg_mode  <= '0;
      r_cfg_seed  <= '0;
      r_remain    <= '0;
      r_beat_left <= '0;
      r_burst_n   <= '0;
      r_act       <= 1'b0;
      r_to_cnt    <= '0;
      r_err       <= '0;
      r_first     <= '0;
      r_timeout   <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cfg_base  <= cfg_base_addr;
            r_cfg_num   <= cfg_num_words;
            r_cfg_burst <= cfg_burst_len;
            r_cfg_mode  <= cfg_pat_mode;
            r_cfg_seed  <= cfg_seed;
            r_remain    <= cfg_num_words;
            r_err       <= '0;
            r_first     <= '0;
            r_timeout   <= 1'b0;
            r_pass      <= 1'b0;
            r_act       <= 1'b0;
          end
        end
        ST_WAIT_INIT, ST_GAP: begin
          if (r_state == ST_GAP || sdr_init_done) begin
            if (r_state == ST_GAP) r_remain <= r_cfg_num;
            r_act       <= 1'b1;
            r_beat_left <= w_burst_next;
            r_burst_n   <= w_burst_next;
            r_to_cnt    <= '0;
          end
        end
        ST_WR, ST_RD: begin
          if (r_act) begin
            if (wb_ack_i) begin
              r_remain <= r_remain - LEN_W'(1);
              r_to_cnt <= '0;
              if (r_beat_left == BURST_W'(1)) r_act <= 1'b0;
              else                            r_beat_left <= r_beat_left - BURST_W'(1);
              if (w_mismatch) begin
                if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
                if (r_err == 16'd0)    r_first <= w_pat_addr;
              end
            end else if (w_to_hit) begin
              r_act     <= 1'b0;
              r_timeout <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end else begin
            // single idle cycle between bursts of the same phase
            r_act       <= 1'b1;
            r_beat_left <= w_burst_next;
            r_burst_n   <= w_burst_next;
            r_to_cnt    <= '0;
          end
        end
        ST_FIN: begin
          r_pass <= w_pass_now;
          r_act  <= 1'b0;
        end
        default: r_act <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sdram_traffic_gen.sv
// Directed bench for wb_sdram_traffic_gen with a memory-backed Wishbone slave.
module tb_wb_sdram_traffic_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        start;
  logic [25:0] cfg_base;
  logic [15:0] cfg_num;
  logic [3:0]  cfg_burst;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_seed;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [25:0] wb_addr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [25:0] first_err_addr;

  typedef struct {
    logic        we;
    logic [25:0] addr;
    logic [31:0] dat;
    logic [2:0]  cti;
    int          cyc;
  } beat_t;

  beat_t       log[$];
  beat_t       mon_b;
  logic [31:0] mem [0:31];
  int          cyc_no = 0;
  int          ack_cnt = 0;
  int          ack_stop;
  logic        corrupt_en;
  logic [25:0] corrupt_addr;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_stb_cyc = 0;
  int          cyc_hi_cnt = 0;
  int          lb, db, cb, s;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [25:0] exp_a [4];
  logic [31:0] exp_l [4];

  always #5 clk = ~clk;

  wb_sdram_traffic_gen dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .sdr_init_done  (init_done),
    .start          (start),
    .cfg_base_addr  (cfg_base),
    .cfg_num_words  (cfg_num),
    .cfg_burst_len  (cfg_burst),
    .cfg_pat_mode   (cfg_mode),
    .cfg_seed       (cfg_seed),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_addr_o      (wb_addr_o),
    .wb_dat_o       (wb_dat_o),
    .wb_sel_o       (wb_sel_o),
    .wb_cti_o       (wb_cti_o),
    .wb_ack_i       (wb_ack_i),
    .wb_dat_i       (wb_dat_i),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .timeout        (timeout)
  );

  // Zero-wait-state slave; acks stop once ack_cnt reaches ack_stop
  assign wb_ack_i = wb_cyc_o && wb_stb_o && (ack_cnt < ack_stop);
  assign wb_dat_i = mem[wb_addr_o[6:2]] ^
                    ((corrupt_en && wb_addr_o == corrupt_addr) ? 32'h1 : 32'h0);

  always @(posedge clk) begin
    cyc_no <= cyc_no + 1;
    if (wb_ack_i) ack_cnt <= ack_cnt + 1;
    if (wb_cyc_o && wb_stb_o && wb_we_o && wb_ack_i) mem[wb_addr_o[6:2]] <= wb_dat_o;
  end

  // Bus/status monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      mon_b.we   = wb_we_o;
      mon_b.addr = wb_addr_o;
      mon_b.dat  = wb_we_o ? wb_dat_o : wb_dat_i;
      mon_b.cti  = wb_cti_o;
      mon_b.cyc  = cyc_no;
      log.push_back(mon_b);
    end
    if (wb_stb_o) last_stb_cyc = cyc_no;
    if (wb_cyc_o) cyc_hi_cnt = cyc_hi_cnt + 1;
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc_no;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle; returns with the bench in the cycle after the pulse
  task automatic run_start(input logic [25:0] base, input logic [15:0] num, input logic [3:0] bl,
                           input logic [1:0] mode, input logic [31:0] seed, output int s_o);
    cfg_base  = base;
    cfg_num   = num;
    cfg_burst = bl;
    cfg_mode  = mode;
    cfg_seed  = seed;
    lb = log.size();
    db = done_cnt;
    cb = cyc_hi_cnt;
    start = 1'b1;
    s_o = cyc_no;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (done_cnt != db) break;
      tick();
    end
    chk("done_seen", done_cnt != db, 1'b1);
  endtask

  initial begin
    rst = 1'b1; init_done = 1'b1; start = 1'b0;
    cfg_base = '0; cfg_num = '0; cfg_burst = '0; cfg_mode = '0; cfg_seed = '0;
    ack_stop = 1 << 30; corrupt_en = 1'b0; corrupt_addr = '0;
    repeat (3) tick();
    chk("reset_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o}, 0);
    chk("reset_status", {busy, done, pass, err_count, first_err_addr, timeout}, 0);
    rst = 1'b0;
    tick();

    // 1: incrementing pattern, two 4-beat bursts per phase
    run_start(26'h100, 16'd8, 4'd4, 2'd0, 32'hA5A5_0000, s);
    chk("s1_busy", busy, 1'b1);
    wait_done(400);
    chk("s1_beats", log.size() - lb, 16);
    for (int i = 0; i < 16; i++) begin
      chk("s1_we",   log[lb+i].we,   (i < 8));
      chk("s1_addr", log[lb+i].addr, 26'h100 + 4 * (i % 8));
      chk("s1_dat",  log[lb+i].dat,  32'hA5A5_0000 + (i % 8));
      chk("s1_cti",  log[lb+i].cti,  ((i % 4) == 3) ? 3'b111 : 3'b010);
      chk("s1_cyc",  log[lb+i].cyc,  s + 2 + 10 * (i / 8) + (i % 8) + ((i % 8) / 4));
    end
    chk("s1_done_cyc", done_cyc, s + 21);
    tick(); tick();
    chk("s1_done_once", done_cnt - db, 1);
    chk("s1_pass", pass, 1'b1);
    chk("s1_err", err_count, 0);
    chk("s1_busy_end", busy, 1'b0);

    // 2: address pattern, bursts of 4 and 1; a start mid-run is ignored
    run_start(26'h100, 16'd5, 4'd4, 2'd1, 32'h0, s);
    tick(); tick();
    cfg_num = 16'd1; cfg_mode = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(400);
    chk("s2_beats", log.size() - lb, 10);
    for (int i = 0; i < 10; i++) begin
      chk("s2_we",   log[lb+i].we,   (i < 5));
      chk("s2_addr", log[lb+i].addr, 26'h100 + 4 * (i % 5));
      chk("s2_dat",  log[lb+i].dat,  32'h100 + 4 * (i % 5));
      chk("s2_cti",  log[lb+i].cti,  ((i % 5) == 4) ? 3'b000 : (((i % 5) == 3) ? 3'b111 : 3'b010));
    end
    chk("s2_done_cyc", done_cyc, s + 15);
    tick();
    chk("s2_pass", pass, 1'b1);
    chk("s2_done_once", done_cnt - db, 1);

    // 3: corrupt read beat 3
    corrupt_en = 1'b1; corrupt_addr = 26'h10C;
    run_start(26'h100, 16'd8, 4'd4, 2'd0, 32'hA5A5_0000, s);
    wait_done(400);
    tick();
    corrupt_en = 1'b0;
    chk("s3_beats", log.size() - lb, 16);
    chk("s3_err", err_count, 1);
    chk("s3_first", first_err_addr, 26'h10C);
    chk("s3_pass", pass, 1'b0);
    chk("s3_timeout", timeout, 1'b0);

    // 4: slave stops acking after 2 beats
    ack_stop = ack_cnt + 2;
    run_start(26'h100, 16'd8, 4'd4, 2'd0, 32'h0, s);
    wait_done(600);
    tick(); tick();
    chk("s4_beats", log.size() - lb, 2);
    chk("s4_last_stb", last_stb_cyc, s + 258);
    chk("s4_done_cyc", done_cyc, s + 259);
    chk("s4_timeout", timeout, 1'b1);
    chk("s4_pass", pass, 1'b0);
    chk("s4_done_once", done_cnt - db, 1);
    ack_stop = 1 << 30;

    // 5: inverted address pattern wrapping the top of the address space
    exp_a[0] = 26'h3FFFFF8; exp_a[1] = 26'h3FFFFFC; exp_a[2] = 26'h0; exp_a[3] = 26'h4;
    run_start(26'h3FFFFF8, 16'd4, 4'd4, 2'd3, 32'h0, s);
    wait_done(400);
    tick();
    chk("s5_beats", log.size() - lb, 8);
    for (int i = 0; i < 8; i++) chk("s5_addr", log[lb+i].addr, exp_a[i % 4]);
    chk("s5_cti_last", log[lb+3].cti, 3'b111);
    chk("s5_pass", pass, 1'b1);

    // 6: LFSR pattern, seed 0 -> 1, burst 2, held off by sdr_init_done
    exp_l[0] = 32'h1; exp_l[1] = 32'h8020_0003; exp_l[2] = 32'hC030_0002; exp_l[3] = 32'h6018_0001;
    init_done = 1'b0;
    run_start(26'h40, 16'd4, 4'd2, 2'd2, 32'h0, s);
    repeat (4) tick();
    chk("s6_no_traffic", log.size() - lb, 0);
    chk("s6_busy_wait", busy, 1'b1);
    chk("s6_cyc_wait", wb_cyc_o, 1'b0);
    init_done = 1'b1;
    wait_done(400);
    tick();
    chk("s6_beats", log.size() - lb, 8);
    for (int i = 0; i < 8; i++) begin
      chk("s6_dat", log[lb+i].dat, exp_l[i % 4]);
      chk("s6_cti", log[lb+i].cti, ((i % 2) == 1) ? 3'b111 : 3'b010);
    end
    chk("s6_pass", pass, 1'b1);

    // 7: reset mid-burst, then an empty run
    run_start(26'h100, 16'd8, 4'd4, 2'd0, 32'h0, s);
    repeat (3) tick();
    chk("s7_mid_stb", wb_stb_o, 1'b1);
    rst = 1'b1;
    tick();
    chk("s7_rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o}, 0);
    chk("s7_rst_status", {busy, done, pass, err_count, first_err_addr, timeout}, 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("s7_no_done", done_cnt - db, 0);
    run_start(26'h100, 16'd0, 4'd4, 2'd0, 32'h0, s);
    chk("s7_done_now", done, 1'b1);
    chk("s7_pass_now", pass, 1'b1);
    chk("s7_busy_now", busy, 1'b0);
    tick();
    chk("s7_done_drop", done, 1'b0);
    chk("s7_pass_held", pass, 1'b1);
    chk("s7_no_bus", cyc_hi_cnt - cb, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
